// File: rtl/i2s_pkg.sv
// Shared defaults and types for the I2S transmit path.
package i2s_pkg;

  localparam int unsigned FRAME_RES_DEF = 32;
  localparam int unsigned DATA_RES_DEF  = 24;

  // Width of a counter that spans both channels of one frame.
  function automatic int unsigned slot_width(input int unsigned frame_res);
    return $clog2(2 * frame_res);
  endfunction

  localparam int unsigned SLOT_W = slot_width(FRAME_RES_DEF);

  typedef logic [DATA_RES_DEF-1:0] sample_t;

  // Word-select encoding on lrck.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair valid/ready handshake into the transmitter.
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_RES = DATA_RES_DEF
) ();

  logic [DATA_RES-1:0] left;
  logic [DATA_RES-1:0] right;
  logic                valid;
  logic                ready;

  modport master (
    output left,
    output right,
    output valid,
    input  ready
  );

  modport slave (
    input  left,
    input  right,
    input  valid,
    output ready
  );

endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: bck toggles every BCK_DIV enabled clk cycles.
// The rise/fall strobes are asserted in the cycle whose clock edge
// performs the toggle, so logic keyed on them updates together with bck.
module i2s_bck_gen #(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bck,
  output logic bck_rise,
  output logic bck_fall
);

  localparam int unsigned DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;

  // Toggle strobes decoded from the divider state.
  always_comb begin
    tick     = en && !reset && (div_cnt == DIV_LAST);
    bck_rise = tick && !bck;
    bck_fall = tick && bck;
  end

  // Divider and bck register; disable behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      bck     <= ~bck;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // The two strobes can never coincide.
  strobe_exclusive: assert property (@(posedge clk) !(bck_rise && bck_fall));

endmodule

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: one-deep sample holding register,
// per-frame load into shift registers, bck/lrck/dat generation.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned FRAME_RES = FRAME_RES_DEF,
  parameter int unsigned DATA_RES  = DATA_RES_DEF,
  parameter int unsigned BCK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  i2s_tx_if.slave    smp,
  output logic       bck_o,
  output logic       lrck_o,
  output logic       dat_o,
  output logic       underrun_o
);

  localparam int unsigned SW = slot_width(FRAME_RES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(2 * FRAME_RES - 1);
  localparam logic [SW-1:0] SLOT_HALF = SW'(FRAME_RES);
  localparam logic [SW-1:0] WORD_LAST = SW'(DATA_RES);

  logic                bck_rise;
  logic                bck_fall;

  logic [SW-1:0]       slot;
  logic [SW-1:0]       slot_nxt;
  logic [SW-1:0]       chan_pos;
  chan_e               chan_sel;
  logic                in_word;
  logic                load;
  logic                shift_l;
  logic                shift_r;
  logic                accept;

  logic                hold_full;
  logic                ready_q;
  logic [DATA_RES-1:0] hold_l;
  logic [DATA_RES-1:0] hold_r;
  logic [DATA_RES-1:0] sh_l;
  logic [DATA_RES-1:0] sh_r;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .bck      (bck_o),
    .bck_rise (bck_rise),
    .bck_fall (bck_fall)
  );

  assign smp.ready = ready_q;

  // Decode of the slot being entered on the next bck fall.
  always_comb begin
    slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
    chan_sel = (slot_nxt >= SLOT_HALF) ? CH_RIGHT : CH_LEFT;
    chan_pos = (chan_sel == CH_RIGHT) ? slot_nxt - SLOT_HALF : slot_nxt;
    in_word  = (chan_pos != '0) && (chan_pos <= WORD_LAST);
    load     = bck_fall && (slot_nxt == '0);
    shift_l  = bck_fall && in_word && (chan_sel == CH_LEFT);
    shift_r  = bck_fall && in_word && (chan_sel == CH_RIGHT);
    accept   = smp.valid && ready_q;
  end

  // Holding register: the frame load empties it before a new pair can land,
  // and acceptance is only possible while it is empty, so the two never clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
    end else if (accept) begin
      hold_full <= 1'b1;
      ready_q   <= 1'b0;
      hold_l    <= smp.left;
      hold_r    <= smp.right;
    end
  end

  // Shift registers: loaded at the slot-0 fall, shifted MSB-first per channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_l <= '0;
      sh_r <= '0;
    end else if (load) begin
      sh_l <= hold_full ? hold_l : '0;
      sh_r <= hold_full ? hold_r : '0;
    end else if (shift_l) begin
      sh_l <= {sh_l[DATA_RES-2:0], 1'b0};
    end else if (shift_r) begin
      sh_r <= {sh_r[DATA_RES-2:0], 1'b0};
    end
  end

  // Slot counter and serial outputs, updated on the same edge as the bck fall.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      slot       <= SLOT_LAST;
      lrck_o     <= 1'b0;
      dat_o      <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= load && !hold_full;
      if (bck_fall) begin
        slot   <= slot_nxt;
        lrck_o <= chan_sel;
        if (shift_l) begin
          dat_o <= sh_l[DATA_RES-1];
        end else if (shift_r) begin
          dat_o <= sh_r[DATA_RES-1];
        end else begin
          dat_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx with BCK_DIV=2 (256 clk cycles per frame).
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int unsigned FR         = 32;
  localparam int unsigned DR         = 24;
  localparam int unsigned BD         = 2;
  localparam int unsigned BCK_CLKS   = 2 * BD;
  localparam int unsigned FRAME_CLKS = 2 * FR * BCK_CLKS;
  localparam int unsigned NV         = 6;

  typedef struct {
    sample_t l;
    sample_t r;
  } pair_t;

  typedef struct {
    sample_t     l;
    sample_t     r;
    int unsigned gap;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic bck_o;
  logic lrck_o;
  logic dat_o;
  logic underrun_o;

  i2s_tx_if #(.DATA_RES(DR)) smp ();

  i2s_tx #(
    .FRAME_RES (FR),
    .DATA_RES  (DR),
    .BCK_DIV   (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .smp        (smp),
    .bck_o      (bck_o),
    .lrck_o     (lrck_o),
    .dat_o      (dat_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Scoreboard: pairs accepted but not yet loaded into a frame.
  pair_t       q[$];
  int unsigned k = 0;
  sample_t     cur_l = '0;
  sample_t     cur_r = '0;
  logic        m_under = 1'b0;
  bit          chk_on = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t (k=%0d): got %b, expected %b", name, $time, k, act, exp);
    end
  endtask

  // Reference timeline: k counts consecutive enabled cycles since reset/enable.
  always @(posedge clk) begin
    bit    acc;
    pair_t p;
    if (reset) begin
      k       = 0;
      q.delete();
      m_under = 1'b0;
    end else begin
      acc     = (smp.valid === 1'b1) && (q.size() == 0);
      k       = en ? k + 1 : 0;
      m_under = 1'b0;
      if (en && k >= BCK_CLKS && ((k - BCK_CLKS) % FRAME_CLKS) == 0) begin
        if (q.size() > 0) begin
          p     = q.pop_front();
          cur_l = p.l;
          cur_r = p.r;
        end else begin
          cur_l   = '0;
          cur_r   = '0;
          m_under = 1'b1;
        end
      end
      if (acc) q.push_back('{smp.left, smp.right});
    end
    chk_on = 1'b1;
  end

  // Compare every output on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    logic        e_bck;
    logic        e_lrck;
    logic        e_dat;
    int unsigned slot;
    int unsigned c;
    if (chk_on) begin
      e_bck = ((k / BD) % 2) == 1;
      if (k < BCK_CLKS) begin
        e_lrck = 1'b0;
        e_dat  = 1'b0;
      end else begin
        slot   = (k / BCK_CLKS - 1) % (2 * FR);
        e_lrck = (slot >= FR);
        c      = slot % FR;
        if (c >= 1 && c <= DR) e_dat = e_lrck ? cur_r[DR-c] : cur_l[DR-c];
        else                   e_dat = 1'b0;
      end
      check("bck",      bck_o,      e_bck);
      check("lrck",     lrck_o,     e_lrck);
      check("dat",      dat_o,      e_dat);
      check("underrun", underrun_o, m_under);
      check("ready",    smp.ready,  (q.size() == 0));
    end
  end

  // Offer a pair and wait (bounded) until the DUT takes it.
  task automatic push(input sample_t l, input sample_t r, input bit keep);
    bit ok = 1'b0;
    smp.left  = l;
    smp.right = r;
    smp.valid = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLKS && !ok; i++) begin
      @(negedge clk);
      ok = (smp.ready === 1'b1);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: ready never high, pair %h/%h not taken", l, r);
    end else begin
      @(posedge clk);
      #1;
    end
    if (!keep) smp.valid = 1'b0;
  endtask

  // Wait until the timeline reaches a given clk offset within the frame.
  task automatic wait_frame_pos(input int unsigned target, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = en && ((k % FRAME_CLKS) == target);
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: frame offset never reached, got k=%0d, expected offset %0d", name, k, target);
    end
  endtask

  vec_t vecs[NV];

  initial begin
    vecs[0] = '{24'hA50F3C, 24'h800001, 0};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 0};
    vecs[2] = '{24'h000000, 24'hFFFFFF, 0};
    vecs[3] = '{24'h7FFFFF, 24'h800000, 5};
    vecs[4] = '{sample_t'($urandom), sample_t'($urandom), 0};
    vecs[5] = '{sample_t'($urandom), sample_t'($urandom), 37};

    // Reset with valid held high: nothing may be accepted.
    reset     = 1'b1;
    en        = 1'b1;
    smp.valid = 1'b1;
    smp.left  = 24'h123456;
    smp.right = 24'h654321;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    smp.valid = 1'b0;

    // Queued pairs, valid kept high back-to-back except where a gap is given.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].gap > 0) begin
        smp.valid = 1'b0;
        repeat (vecs[i].gap) @(posedge clk);
        #1;
      end
      push(vecs[i].l, vecs[i].r, (i != NV - 1));
    end

    // Drain the last frame, then run dry to see underruns.
    repeat (FRAME_CLKS + 10) @(posedge clk);
    repeat (3 * FRAME_CLKS) @(posedge clk);
    #1;

    // Drop en at slot 10 with a pair held; it must survive and play after restart.
    wait_frame_pos(2 * BCK_CLKS, "en_seq_slot1");
    push(24'hC3A5F0, 24'h0F0F0F, 1'b0);
    wait_frame_pos(BCK_CLKS + 10 * BCK_CLKS, "en_seq_slot10");
    en = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    en = 1'b1;
    repeat (2 * FRAME_CLKS) @(posedge clk);
    #1;

    // Same with reset: the held pair must be discarded.
    wait_frame_pos(2 * BCK_CLKS, "rst_seq_slot1");
    push(24'h5A5A5A, 24'hA5A5A5, 1'b0);
    wait_frame_pos(BCK_CLKS + 10 * BCK_CLKS, "rst_seq_slot10");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (FRAME_CLKS + 20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
